// File: rtl/maze_pkg.sv
// Shared maze constants, level codes and loader state type.
// Used by the loader, the draw block and the player-movement block.
package maze_pkg;

  localparam int unsigned MAP_BITS   = 1200;
  localparam int unsigned COLS       = 40;
  localparam int unsigned ROWS       = 30;
  localparam int unsigned MAP_WORDS  = 75;
  localparam int unsigned HDR_PLAYER = 75;
  localparam int unsigned HDR_GOAL   = 76;

  localparam logic [1:0] LV_EZ = 2'd1;
  localparam logic [1:0] LV_MI = 2'd2;
  localparam logic [1:0] LV_HD = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDone,
    StErr
  } loader_state_e;

  // Header word: X in [10:5], Y in [4:0]; both must land inside the grid.
  function automatic logic hdr_ok(input logic [15:0] word);
    return (word[10:5] < 6'(COLS)) && (word[4:0] < 5'(ROWS));
  endfunction

endpackage

// File: rtl/map_loader.sv
// Streams one maze level out of the level ROM into the map register and
// the player/goal start positions, flagging done or error at the end.
module map_loader #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned MAP_WORDS = 75
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Start,
  input  logic [1:0]                  i_Level,
  output logic [ADDR_W-1:0]           o_RomAddr,
  input  logic [DATA_W-1:0]           i_RomData,
  output logic [DATA_W*MAP_WORDS-1:0] o_Map,
  output logic [5:0]                  o_PlayerPos_X,
  output logic [4:0]                  o_PlayerPos_Y,
  output logic [5:0]                  o_GoalPos_X,
  output logic [4:0]                  o_GoalPos_Y,
  output logic                        o_Busy,
  output logic                        o_fLoadDone,
  output logic                        o_fError
);
  import maze_pkg::*;

  localparam int unsigned MapW    = DATA_W * MAP_WORDS;
  localparam logic [6:0]  LastMap = 7'(MAP_WORDS - 1);
  localparam logic [6:0]  WPlayer = 7'(HDR_PLAYER);
  localparam logic [6:0]  WGoal   = 7'(HDR_GOAL);

  loader_state_e         r_state, w_stateNext;
  logic [MapW-1:0]       r_map;
  logic [ADDR_W-1:0]     r_addr;
  logic [6:0]            r_cnt;
  logic [1:0]            r_lvlIdx;
  logic                  r_capValid;
  logic                  r_hdrErr;
  logic [5:0]            r_px, r_gx;
  logic [4:0]            r_py, r_gy;

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_last;
  logic                  w_hdrOk;
  logic [1:0]            w_lvlIdx;
  logic [6:0]            w_cntInc;

  assign w_lvlIdx  = i_Level - 2'd1;
  assign w_cntInc  = r_cnt + 7'd1;
  assign w_capture = (r_state == StFetch) && r_capValid;
  assign w_last    = w_capture && (r_cnt == WGoal);
  assign w_hdrOk   = hdr_ok(i_RomData);

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      StIdle, StDone, StErr: begin
        if (i_Start) begin
          if (i_Level != 2'd0) begin
            w_stateNext = StFetch;
            w_accept    = 1'b1;
          end else begin
            w_stateNext = StErr;
          end
        end
      end
      StFetch: begin
        // Start is ignored here, including on the completing edge.
        if (w_last) begin
          w_stateNext = (r_hdrErr || !w_hdrOk) ? StErr : StDone;
        end
      end
      default: w_stateNext = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_map      <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_lvlIdx   <= '0;
      r_capValid <= 1'b0;
      r_hdrErr   <= 1'b0;
      r_px       <= '0;
      r_py       <= '0;
      r_gx       <= '0;
      r_gy       <= '0;
    end else if (w_accept) begin
      r_lvlIdx   <= w_lvlIdx;
      r_cnt      <= '0;
      r_addr     <= ADDR_W'({w_lvlIdx, 7'd0});
      r_capValid <= 1'b1;
      r_hdrErr   <= 1'b0;
    end else if (w_capture) begin
      if (r_cnt <= LastMap) begin
        r_map <= {r_map[MapW-DATA_W-1:0], i_RomData};
      end else begin
        // Positions are written even when out of range; the flag records it.
        if (r_cnt == WPlayer) begin
          r_px <= i_RomData[10:5];
          r_py <= i_RomData[4:0];
        end else begin
          r_gx <= i_RomData[10:5];
          r_gy <= i_RomData[4:0];
        end
        if (!w_hdrOk) r_hdrErr <= 1'b1;
      end
      if (r_cnt == WGoal) begin
        r_capValid <= 1'b0;
      end else begin
        r_cnt  <= w_cntInc;
        r_addr <= ADDR_W'({r_lvlIdx, w_cntInc});
      end
    end
  end

  assign o_RomAddr     = r_addr;
  assign o_Map         = r_map;
  assign o_PlayerPos_X = r_px;
  assign o_PlayerPos_Y = r_py;
  assign o_GoalPos_X   = r_gx;
  assign o_GoalPos_Y   = r_gy;
  assign o_Busy        = (r_state == StFetch);
  assign o_fLoadDone   = (r_state == StDone);
  assign o_fError      = (r_state == StErr);

endmodule

// File: tb/tb_map_loader.sv
// Randomized self-checking bench for map_loader against a level-image
// reference model of the ROM contents.
module tb_map_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   level;
  logic [8:0]   rom_addr;
  logic [15:0]  rom_data;
  logic [1199:0] map;
  logic [5:0]   px, gx;
  logic [4:0]   py, gy;
  logic         busy, done, err;

  logic [15:0]  rom [512];

  always #5 clk = ~clk;

  // The loader captures the word for the address it drove on the next edge.
  assign rom_data = rom[rom_addr];

  map_loader #(
    .DATA_W   (16),
    .ADDR_W   (9),
    .MAP_WORDS(75)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst_n),
    .i_Start      (start),
    .i_Level      (level),
    .o_RomAddr    (rom_addr),
    .i_RomData    (rom_data),
    .o_Map        (map),
    .o_PlayerPos_X(px),
    .o_PlayerPos_Y(py),
    .o_GoalPos_X  (gx),
    .o_GoalPos_Y  (gy),
    .o_Busy       (busy),
    .o_fLoadDone  (done),
    .o_fError     (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [1199:0] exp_map;
  logic [5:0]    exp_px, exp_gx;
  logic [4:0]    exp_py, exp_gy;
  logic          exp_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  function automatic logic [15:0] hdr_word(input int x, input int y);
    logic [15:0] w;
    w = 16'($urandom);
    w[10:5] = 6'(x);
    w[4:0]  = 5'(y);
    return w;
  endfunction

  task automatic fill_level(input int lvl, input int hx_max, input int hy_max);
    int base;
    base = (lvl - 1) * 128;
    for (int i = 0; i < 75; i++) rom[base + i] = 16'($urandom);
    rom[base + 75] = hdr_word($urandom_range(0, hx_max), $urandom_range(0, hy_max));
    rom[base + 76] = hdr_word($urandom_range(0, hx_max), $urandom_range(0, hy_max));
  endtask

  // Expected image of a completed load: 75 map words top-first, then two headers.
  task automatic model_load(input int lvl);
    int base;
    logic [15:0] w;
    base = (lvl - 1) * 128;
    for (int i = 0; i < 75; i++) exp_map[1199 - 16 * i -: 16] = rom[base + i];
    w = rom[base + 75];
    exp_px = w[10:5];
    exp_py = w[4:0];
    w = rom[base + 76];
    exp_gx = w[10:5];
    exp_gy = w[4:0];
    exp_err = (exp_px >= 6'd40) || (exp_py >= 5'd30) || (exp_gx >= 6'd40) || (exp_gy >= 5'd30);
  endtask

  task automatic check_image(input string tag);
    for (int i = 0; i < 75; i++) begin
      check($sformatf("%s_map_w%0d", tag, i), 32'(map[1199 - 16 * i -: 16]),
            32'(exp_map[1199 - 16 * i -: 16]));
    end
    check({tag, "_px"}, 32'(px), 32'(exp_px));
    check({tag, "_py"}, 32'(py), 32'(exp_py));
    check({tag, "_gx"}, 32'(gx), 32'(exp_gx));
    check({tag, "_gy"}, 32'(gy), 32'(exp_gy));
  endtask

  // Full load; optionally pulses start (with a new level) before edge pulse_at.
  task automatic run_load(input string tag, input int lvl, input int pulse_at, input int lvl_mid);
    int base;
    int a;
    base = (lvl - 1) * 128;
    model_load(lvl);
    @(negedge clk);
    level = 2'(lvl);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    check({tag, "_addr_e0"}, 32'(rom_addr), 32'(base));
    check({tag, "_done_e0"}, 32'(done), 32'd0);
    check({tag, "_err_e0"}, 32'(err), 32'd0);
    for (int k = 1; k <= 77; k++) begin
      @(negedge clk);
      if (k == pulse_at) begin
        start = 1'b1;
        level = 2'(lvl_mid);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k < 77) begin
        a = base + ((k < 76) ? k : 76);
        check($sformatf("%s_addr_%0d", tag, k), 32'(rom_addr), 32'(a));
        check($sformatf("%s_busy_%0d", tag, k), 32'(busy), 32'd1);
        check($sformatf("%s_done_%0d", tag, k), 32'(done), 32'd0);
      end
    end
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_done_end"}, 32'(done), 32'(!exp_err));
    check({tag, "_err_end"}, 32'(err), 32'(exp_err));
    check({tag, "_addr_end"}, 32'(rom_addr), 32'(base + 76));
    check_image(tag);
    @(posedge clk);
    #1;
    check({tag, "_busy_hold"}, 32'(busy), 32'd0);
    check({tag, "_done_hold"}, 32'(done), 32'(!exp_err));
    check({tag, "_err_hold"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [8:0] addr_before;
    int lvl;

    rst_n = 1'b0;
    start = 1'b0;
    level = 2'd0;
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
    exp_map = '0;
    exp_px  = '0;
    exp_py  = '0;
    exp_gx  = '0;
    exp_gy  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_map_zero", 32'(map == '0), 32'd1);
    check("rst_pos", 32'({px, py, gx, gy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Level 1 with word n = n * 0x0101.
    for (int i = 0; i < 75; i++) rom[i] = 16'(i * 16'h0101);
    rom[75] = hdr_word($urandom_range(0, 39), $urandom_range(0, 29));
    rom[76] = hdr_word($urandom_range(0, 39), $urandom_range(0, 29));
    run_load("lv1", 1, -1, 0);
    check("lv1_top_word", 32'(map[1199:1184]), 32'h0000);
    check("lv1_bot_word", 32'(map[15:0]), 32'h4A4A);

    // Level 3 with fixed headers.
    fill_level(3, 39, 29);
    rom[256 + 75] = 16'h0105;
    rom[256 + 76] = 16'h04E3;
    run_load("lv3", 3, -1, 0);
    check("lv3_px", 32'(px), 32'd8);
    check("lv3_py", 32'(py), 32'd5);
    check("lv3_gx", 32'(gx), 32'd39);
    check("lv3_gy", 32'(gy), 32'd3);
    check("lv3_done", 32'(done), 32'd1);
    check("lv3_err", 32'(err), 32'd0);

    // Player X = 40 is out of range.
    fill_level(2, 39, 29);
    rom[128 + 75] = 16'h0500;
    run_load("badx", 2, -1, 0);
    check("badx_err", 32'(err), 32'd1);
    check("badx_done", 32'(done), 32'd0);

    // Invalid level: immediate error, no ROM access, image untouched.
    addr_before = rom_addr;
    @(negedge clk);
    level = 2'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("lv0_err", 32'(err), 32'd1);
    check("lv0_busy", 32'(busy), 32'd0);
    check("lv0_done", 32'(done), 32'd0);
    check("lv0_addr", 32'(rom_addr), 32'(addr_before));
    check_image("lv0");

    // Start pulsed mid-load with a different level, and on the completing edge.
    fill_level(1, 39, 29);
    fill_level(2, 39, 29);
    run_load("mid", 1, 30, 2);
    fill_level(3, 39, 29);
    run_load("edge", 3, 77, 1);

    // Reset at word 40 of a level-2 load.
    fill_level(2, 39, 29);
    @(negedge clk);
    level = 2'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rst40_addr", 32'(rom_addr), 32'(128 + 40));
    rst_n = 1'b0;
    #1;
    check("rst40_busy", 32'(busy), 32'd0);
    check("rst40_done", 32'(done), 32'd0);
    check("rst40_err", 32'(err), 32'd0);
    check("rst40_addr0", 32'(rom_addr), 32'd0);
    check("rst40_map_zero", 32'(map == '0), 32'd1);
    check("rst40_pos", 32'({px, py, gx, gy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_level(1, 39, 29);
    run_load("after_rst", 1, -1, 0);

    // Random levels; header ranges straddle the grid edges.
    for (int t = 0; t < 6; t++) begin
      lvl = $urandom_range(1, 3);
      fill_level(lvl, 45, 33);
      run_load($sformatf("rnd%0d", t), lvl, (t % 2 == 0) ? $urandom_range(1, 77) : -1,
               $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
